bitplane_raster_gen: RTL and testbench
======================================

BITPLANE_RASTER_GEN -- requirements
Module: bitplane_raster_gen

Interface
REQ-001 SHALL have parameter PIPE_DELAY, default 3: input-to-output latency in pixel strobes; legal range 2..15.
REQ-002 SHALL have parameter X_WIDTH, default 10: width of x_in and x_out.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port pc_ena, input, 4: pixel phase; a cycle with pc_ena==0 is a "strobe".
REQ-006 SHALL have port ram_byte_in, input, 8: bitplane or character byte.
REQ-007 SHALL have port ram_byte_h, input, 8: high or attribute byte in two-byte modes.
REQ-008 SHALL have port bg_colour, input, 8: default colour pair, with fg in [7:4] and bg in [3:0].
REQ-009 SHALL have port x_in, input, X_WIDTH: source pixel X.
REQ-010 SHALL have port colour_mode_in, input, 2: 0=1bpp, 1=2bpp, 2=4bpp, 3=8bpp.
REQ-011 SHALL have port two_byte_mode, input, 1: selects 16-bit interpretation.
REQ-012 SHALL have port frame_tick, input, 1: one-clock pulse per frame.
REQ-013 SHALL have port pixel_out_ena, output, 1: one-clock valid pulse.
REQ-014 SHALL have ports pixel_out and pixel_out_h, each output, 8: pixel low and high bytes.
REQ-015 SHALL have ports x_out (output, X_WIDTH), colour_mode_out (output, 2) and mode_16bit (output, 1): aligned sideband.

Function
REQ-016 SHALL advance the pipeline and update outputs only on strobes; on non-strobe cycles all state SHALL hold and pixel_out_ena SHALL be 0.
REQ-017 SHALL delay x_in, ram_byte_in, ram_byte_h, colour_mode_in and two_byte_mode through a common PIPE_DELAY-stage pipe.
REQ-018 SHALL perform all decode on the delayed, aligned mode and data, never on the undelayed inputs.
REQ-019 SHALL present inputs sampled at strobe n on the outputs on the clock after strobe n+PIPE_DELAY-1, giving a latency of exactly PIPE_DELAY strobes.
REQ-020 SHALL drive x_out, colour_mode_out and mode_16bit from the same pipe stage as pixel data.
REQ-021 SHALL implement a fill counter that saturates at PIPE_DELAY strobes after reset.
REQ-022 SHALL pulse pixel_out_ena high for the one clock following each strobe once the fill counter is saturated, and keep it 0 otherwise.
REQ-023 SHALL, in 8-bit mode 0, take b = byte[7-x[2:0]] (MSB = leftmost) and output pixel_out = {3'b000, b, b ? bg[7:4] : bg[3:0]}.
REQ-024 SHALL, in 8-bit mode 1, output pixel_out = {6'b0, byte[7-2k:6-2k]} with k = x[2:1].
REQ-025 SHALL, in 8-bit mode 2, output pixel_out = {4'b0, x[2] ? byte[3:0] : byte[7:4]}.
REQ-026 SHALL, in 8-bit mode 3, output pixel_out = byte.
REQ-027 SHALL, in all 8-bit modes, output pixel_out_h = 0 and mode_16bit = 0.
REQ-028 SHALL, in 16-bit mode 0 (colour text), output pixel_out = byte and mode_16bit = 0, with attr = ram_byte_h.
REQ-029 SHALL, in 16-bit mode 0, output pixel_out_h = {4'h0, attr[3:0]} when b=1 and {5'h00, attr[6:4]} when b=0, where b is the bit defined in REQ-023.
REQ-030 SHALL, in 16-bit mode 3, output pixel_out = byte, pixel_out_h = high byte and mode_16bit = 1.
REQ-031 SHALL, in reserved 16-bit modes 1 and 2, output pixel_out = bg_colour, pixel_out_h = 0 and mode_16bit = 0.
REQ-032 SHALL allow a mode change between consecutive strobes to take effect exactly at the aligned pixel, with no blended pixel.
REQ-033 SHALL allow x to wrap with no special handling, since only x[2:0] is decoded.

Reset
REQ-034 SHALL, while reset=1 at a clock edge, clear all outputs, pipe stages, the fill counter and the blink counter to 0 regardless of pc_ena.
REQ-035 SHALL, after a reset asserted mid-line, hold pixel_out_ena at 0 for the next PIPE_DELAY strobes.

Configuration
REQ-036 SHALL provide macro BITPLANE_RASTER_BLINK_EN.
REQ-037 SHALL, when BITPLANE_RASTER_BLINK_EN is defined, count frame_tick pulses in a 6-bit counter and let phase = counter[5].
REQ-038 SHALL, when BITPLANE_RASTER_BLINK_EN is defined, in 16-bit mode 0 with attr[7]=1 and phase=1, output the background value for foreground pixels.
REQ-039 SHALL, when BITPLANE_RASTER_BLINK_EN is undefined, omit the counter, ignore frame_tick, and leave attr[7] with no effect.

Verification
REQ-040 SHALL cover: PIPE_DELAY=3; reset, then mode 0 8-bit, byte=0x80, bg=0xA5, x=0..7 -> first pixel_out_ena 3 strobes after the first input; pixel_out sequence 0x1A followed by 0x05 x7.
REQ-041 SHALL cover: mode 1 8-bit, byte=0x1B, x=0..7 -> pixel_out 0,0,1,1,2,2,3,3.
REQ-042 SHALL cover: 16-bit mode 0, byte=0x81, attr=0x2C, x=0..7 -> pixel_out_h 0x0C,0x02,0x02,0x02,0x02,0x02,0x02,0x0C; pixel_out=0x81 throughout.
REQ-043 SHALL cover: 16-bit mode 3, bytes 0x12/0x34 -> pixel_out=0x12, pixel_out_h=0x34, mode_16bit=1 aligned to x_out.
REQ-044 SHALL cover: pc_ena cycling 0..15 with reset pulsed mid-line -> outputs zero on the next clock, pixel_out_ena silent for 3 strobes, and no output change on non-strobe cycles.
REQ-045 SHALL cover, with BITPLANE_RASTER_BLINK_EN defined: 32 frame_tick pulses, attr=0x8C, b=1 -> pixel_out_h=0x00; with attr=0x0C -> 0x0C.

Source files
------------

// File: rtl/bitplane_raster_gen_if.sv
// Signal bundle between a pixel source (master) and the bitplane raster generator (slave).
interface bitplane_raster_gen_if #(
  parameter int X_WIDTH = 10
);
  logic [3:0]         pc_ena;
  logic [7:0]         ram_byte_in;
  logic [7:0]         ram_byte_h;
  logic [7:0]         bg_colour;
  logic [X_WIDTH-1:0] x_in;
  logic [1:0]         colour_mode_in;
  logic               two_byte_mode;
  logic               frame_tick;

  logic               pixel_out_ena;
  logic [7:0]         pixel_out;
  logic [7:0]         pixel_out_h;
  logic [X_WIDTH-1:0] x_out;
  logic [1:0]         colour_mode_out;
  logic               mode_16bit;

  modport master (
    output pc_ena, ram_byte_in, ram_byte_h, bg_colour, x_in, colour_mode_in,
           two_byte_mode, frame_tick,
    input  pixel_out_ena, pixel_out, pixel_out_h, x_out, colour_mode_out, mode_16bit
  );

  modport slave (
    input  pc_ena, ram_byte_in, ram_byte_h, bg_colour, x_in, colour_mode_in,
           two_byte_mode, frame_tick,
    output pixel_out_ena, pixel_out, pixel_out_h, x_out, colour_mode_out, mode_16bit
  );
endinterface

// File: rtl/bitplane_raster_gen.sv
// Bitplane/text pixel decoder: PIPE_DELAY-strobe latency, advances only on pc_ena==0 strobes (no backpressure).
// Optional attribute blink enabled by defining BITPLANE_RASTER_BLINK_EN.
module bitplane_raster_gen #(
  parameter int PIPE_DELAY = 3,
  parameter int X_WIDTH    = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  bitplane_raster_gen_if.slave bus
);

  typedef struct packed {
    logic [X_WIDTH-1:0] x;
    logic [7:0]         lo;
    logic [7:0]         hi;
    logic [1:0]         mode;
    logic               two;
  } stage_t;

  // The output register is the final stage, so the pipe proper is one shorter.
  localparam int         NSTAGE   = PIPE_DELAY - 1;
  localparam logic [3:0] FILL_MAX = 4'(PIPE_DELAY);

  logic               strobe;
  stage_t             in_s;
  stage_t             stage_q [NSTAGE];
  stage_t             tail;
  logic [2:0]         xs;
  logic               bit_sel;
  logic               fg_shown;
  logic               blink_phase;

  logic [3:0]         fill_q, fill_d;
  logic               ena_q, ena_d;
  logic [7:0]         pix_lo_q, pix_lo_d;
  logic [7:0]         pix_hi_q, pix_hi_d;
  logic               m16_q, m16_d;
  logic [X_WIDTH-1:0] x_q;
  logic [1:0]         mode_q;

  assign strobe   = (bus.pc_ena == 4'd0);
  assign in_s     = {bus.x_in, bus.ram_byte_in, bus.ram_byte_h, bus.colour_mode_in,
                     bus.two_byte_mode};
  assign tail     = stage_q[NSTAGE-1];
  assign xs       = tail.x[2:0];
  assign bit_sel  = tail.lo[3'd7 - xs];
  assign fg_shown = bit_sel & ~(blink_phase & tail.hi[7]);

  assign fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 4'd1;
  assign ena_d  = strobe && (fill_d == FILL_MAX);

`ifdef BITPLANE_RASTER_BLINK_EN
  logic [5:0] blink_q, blink_d;

  assign blink_d     = bus.frame_tick ? blink_q + 6'd1 : blink_q;
  assign blink_phase = blink_q[5];

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end
`else
  logic unused_frame_tick;

  assign unused_frame_tick = bus.frame_tick;
  assign blink_phase       = 1'b0;
`endif

  // Decode always works on the aligned tail stage; only bg_colour is taken live.
  always_comb begin
    pix_lo_d = '0;
    pix_hi_d = '0;
    m16_d    = 1'b0;
    if (!tail.two) begin
      case (tail.mode)
        2'd0: pix_lo_d = {3'b000, bit_sel,
                          bit_sel ? bus.bg_colour[7:4] : bus.bg_colour[3:0]};
        2'd1: begin
          case (xs[2:1])
            2'd0:    pix_lo_d = {6'b0, tail.lo[7:6]};
            2'd1:    pix_lo_d = {6'b0, tail.lo[5:4]};
            2'd2:    pix_lo_d = {6'b0, tail.lo[3:2]};
            default: pix_lo_d = {6'b0, tail.lo[1:0]};
          endcase
        end
        2'd2:    pix_lo_d = {4'b0, xs[2] ? tail.lo[3:0] : tail.lo[7:4]};
        default: pix_lo_d = tail.lo;
      endcase
    end else begin
      case (tail.mode)
        2'd0: begin
          pix_lo_d = tail.lo;
          pix_hi_d = fg_shown ? {4'h0, tail.hi[3:0]} : {5'h00, tail.hi[6:4]};
        end
        2'd3: begin
          pix_lo_d = tail.lo;
          pix_hi_d = tail.hi;
          m16_d    = 1'b1;
        end
        default: pix_lo_d = bus.bg_colour;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSTAGE; i++) begin
        stage_q[i] <= '0;
      end
      fill_q   <= '0;
      ena_q    <= 1'b0;
      pix_lo_q <= '0;
      pix_hi_q <= '0;
      m16_q    <= 1'b0;
      x_q      <= '0;
      mode_q   <= '0;
    end else if (strobe) begin
      stage_q[0] <= in_s;
      for (int i = 1; i < NSTAGE; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      fill_q   <= fill_d;
      ena_q    <= ena_d;
      pix_lo_q <= pix_lo_d;
      pix_hi_q <= pix_hi_d;
      m16_q    <= m16_d;
      x_q      <= tail.x;
      mode_q   <= tail.mode;
    end else begin
      ena_q <= 1'b0;
    end
  end

  assign bus.pixel_out_ena   = ena_q;
  assign bus.pixel_out       = pix_lo_q;
  assign bus.pixel_out_h     = pix_hi_q;
  assign bus.mode_16bit      = m16_q;
  assign bus.x_out           = x_q;
  assign bus.colour_mode_out = mode_q;

endmodule

// File: tb/tb_bitplane_raster_gen.sv
// Randomized and directed bench for bitplane_raster_gen against a queue-based pixel model.
module tb_bitplane_raster_gen;
  localparam int P  = 3;
  localparam int XW = 10;
`ifdef BITPLANE_RASTER_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  typedef struct {
    int x;
    int lo;
    int hi;
    int mode;
    int two;
  } rec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bitplane_raster_gen_if #(.X_WIDTH(XW)) bus ();

  bitplane_raster_gen #(.PIPE_DELAY(P), .X_WIDTH(XW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  rec_t       pend[$];
  int         strobes;
  int         ticks;
  int         bg_v;
  bit         known;
  int         e_ena, e_lo, e_hi, e_x, e_mode, e_m16;
  logic [7:0] seen_lo[$];
  logic [7:0] seen_hi[$];

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic rec_t mk(input int x, input int lo, input int hi, input int mode, input int two);
    rec_t r;
    r.x = x; r.lo = lo; r.hi = hi; r.mode = mode; r.two = two;
    return r;
  endfunction

  function automatic rec_t rnd_rec();
    return mk(int'($urandom_range(1023, 0)), int'($urandom_range(255, 0)),
              int'($urandom_range(255, 0)), int'($urandom_range(3, 0)),
              ($urandom_range(3, 0) == 0) ? 1 : 0);
  endfunction

  // Pixel value straight from the mode rules, using plain arithmetic on the byte.
  function automatic void ref_pixel(input rec_t r, input int bg, input int phase,
                                    output int lo, output int hi, output int m16);
    int xi, b, hide;
    xi  = r.x % 8;
    b   = (r.lo >> (7 - xi)) & 1;
    lo  = 0; hi = 0; m16 = 0;
    if (r.two == 0) begin
      case (r.mode)
        0:       lo = (b == 1) ? 16 + bg / 16 : bg % 16;
        1:       lo = (r.lo >> (6 - 2 * (xi / 2))) & 3;
        2:       lo = (xi >= 4) ? r.lo % 16 : r.lo / 16;
        default: lo = r.lo;
      endcase
    end else begin
      case (r.mode)
        0: begin
          lo   = r.lo;
          hide = (BLINK && r.hi >= 128 && phase == 1) ? 1 : 0;
          hi   = (b == 1 && hide == 0) ? r.hi % 16 : (r.hi / 16) % 8;
        end
        3: begin
          lo = r.lo; hi = r.hi; m16 = 1;
        end
        default: lo = bg;
      endcase
    end
  endfunction

  function automatic void model_reset();
    pend.delete();
    for (int i = 0; i < P - 1; i++) pend.push_back(mk(0, 0, 0, 0, 0));
    strobes = 0;
    ticks   = 0;
    known   = 1'b1;
    e_ena = 0; e_lo = 0; e_hi = 0; e_x = 0; e_mode = 0; e_m16 = 0;
  endfunction

  task automatic step(input int pc, input rec_t r, input bit ft, input bit rst);
    rec_t o;
    int lo, hi, m16;
    bus.pc_ena         = 4'(pc);
    bus.ram_byte_in    = 8'(r.lo);
    bus.ram_byte_h     = 8'(r.hi);
    bus.x_in           = XW'(r.x);
    bus.colour_mode_in = 2'(r.mode);
    bus.two_byte_mode  = (r.two != 0);
    bus.frame_tick     = ft;
    bus.bg_colour      = 8'(bg_v);
    reset              = rst;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (pc == 0) begin
        pend.push_back(r);
        o = pend.pop_front();
        strobes++;
        ref_pixel(o, bg_v, (ticks / 32) % 2, lo, hi, m16);
        e_ena  = (strobes >= P) ? 1 : 0;
        known  = (e_ena == 1);
        e_lo   = lo; e_hi = hi; e_m16 = m16;
        e_x    = o.x % 1024;
        e_mode = o.mode;
      end else begin
        e_ena = 0;
      end
      if (ft) ticks++;
    end
    #1;
    expect_eq("pixel_out_ena", 32'(bus.pixel_out_ena), e_ena);
    if (bus.pixel_out_ena) begin
      seen_lo.push_back(bus.pixel_out);
      seen_hi.push_back(bus.pixel_out_h);
    end
    if (known) begin
      expect_eq("pixel_out", 32'(bus.pixel_out), e_lo);
      expect_eq("pixel_out_h", 32'(bus.pixel_out_h), e_hi);
      expect_eq("mode_16bit", 32'(bus.mode_16bit), e_m16);
      expect_eq("x_out", 32'(bus.x_out), e_x);
      expect_eq("colour_mode_out", 32'(bus.colour_mode_out), e_mode);
    end
  endtask

  task automatic feed(input rec_t r, input int gap, input int ft_pct);
    for (int i = 0; i < gap; i++)
      step(int'($urandom_range(15, 1)), rnd_rec(), ($urandom_range(99, 0) < ft_pct), 1'b0);
    step(0, r, ($urandom_range(99, 0) < ft_pct / 4), 1'b0);
  endtask

  task automatic do_reset();
    step(int'($urandom_range(15, 0)), rnd_rec(), 1'b0, 1'b1);
    step(int'($urandom_range(15, 0)), rnd_rec(), 1'b0, 1'b1);
    seen_lo.delete();
    seen_hi.delete();
  endtask

  // Eight pixels x=0..7 of one record, then P-1 flush strobes.
  task automatic run_line(input int lo, input int hi, input int mode, input int two);
    for (int x = 0; x < 8 + P - 1; x++)
      feed(mk(x, lo, hi, mode, two), int'($urandom_range(2, 0)), 0);
  endtask

  task automatic check_seen(input string tag, input logic [7:0] want[8], input bit use_hi);
    expect_eq({tag, "_count"}, 32'(seen_lo.size()), 8);
    for (int i = 0; i < 8 && i < seen_lo.size(); i++)
      expect_eq(tag, use_hi ? seen_hi[i] : seen_lo[i], want[i]);
  endtask

  task automatic blink_case(input int attr, input logic [7:0] want_h);
    logic [7:0] w[8];
    do_reset();
    for (int i = 0; i < 32; i++) step(5, rnd_rec(), 1'b1, 1'b0);
    run_line(8'hFF, attr, 0, 1);
    for (int i = 0; i < 8; i++) w[i] = want_h;
    check_seen("blink_h", w, 1'b1);
  endtask

  initial begin
    logic [7:0] w[8];
    bg_v = 8'hA5;
    bus.pc_ena = 4'd0; bus.ram_byte_in = '0; bus.ram_byte_h = '0; bus.x_in = '0;
    bus.colour_mode_in = '0; bus.two_byte_mode = 1'b0; bus.frame_tick = 1'b0;
    bus.bg_colour = 8'hA5;
    model_reset();

    do_reset();
    run_line(8'h80, 0, 0, 0);
    w = '{8'h1A, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05};
    check_seen("mode0_8b", w, 1'b0);

    do_reset();
    run_line(8'h1B, 8'hEE, 1, 0);
    w = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03};
    check_seen("mode1_8b", w, 1'b0);

    do_reset();
    run_line(8'h81, 8'h2C, 0, 1);
    w = '{8'h0C, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h0C};
    check_seen("text_attr", w, 1'b1);
    for (int i = 0; i < 8; i++) w[i] = 8'h81;
    check_seen("text_char", w, 1'b0);

    do_reset();
    run_line(8'h12, 8'h34, 3, 1);
    for (int i = 0; i < 8; i++) w[i] = 8'h34;
    check_seen("m16_hi", w, 1'b1);

    do_reset();
    for (int line = 0; line < 7; line++) begin
      for (int c = 0; c < 16; c++) begin
        step(c, mk(line, int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
                   int'($urandom_range(3, 0)), line % 2), 1'b0, (line == 2 && c == 9));
      end
    end

    do_reset();
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(149, 0) == 0) step(int'($urandom_range(15, 0)), rnd_rec(), 1'b0, 1'b1);
      if ($urandom_range(31, 0) == 0) bg_v = int'($urandom_range(255, 0));
      feed(rnd_rec(), int'($urandom_range(3, 0)), 30);
    end

    blink_case(8'h8C, BLINK ? 8'h00 : 8'h0C);
    blink_case(8'h0C, 8'h0C);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
